// File: rtl/trap_sequencer.sv
// trap_sequencer: takes synchronous exceptions and system instructions from
// the pipeline, records the trap CSR values, flushes the pipe for one cycle
// and then holds a PC redirect until fetch accepts it.
//
// Optional build macro TRAP_MTVAL_EN: when defined, mtval_out carries the
// faulting address / instruction word (or pc_in for ebreak). When undefined,
// mtval_out is tied to zero and no mtval storage exists.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for an event; the only state that samples events
// FLUSH    | one cycle with flush = 1 to kill in-flight instructions
// REDIRECT | redirect_valid = 1, redirect_pc held until redirect_ready

module trap_sequencer (
   input  logic        clk,
   input  logic        resetb,
   input  logic        FD_exception_instruction_misaligned,
   input  logic        FD_exception_illegal_instruction,
   input  logic        FD_exception_unsupported_category,
   input  logic        FD_exception_memory_misaligned,
   input  logic        is_store,
   input  logic        XB_exception_machine_trap,
   input  logic        ecall,
   input  logic        ebreak,
   input  logic        mret,
   input  logic [31:0] pc_in,
   input  logic [31:0] bad_value,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc_in,
   input  logic        redirect_ready,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        trap_we,
   output logic [31:0] mepc_out,
   output logic [31:0] mcause_out,
   output logic [31:0] mtval_out,
   output logic        busy,
   output logic [15:0] trap_count
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;

   localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'd0;
   localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
   localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
   localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
   localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
   localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;

   state_t      state;
   logic        trap_hit;
   logic [3:0]  trap_cause;
   logic        trap_taken;
   logic [15:0] count_next;

   // Low PC/mtvec bits are dropped by alignment, and bad_value is only
   // consumed when mtval storage is built in.
   logic unused_inputs;
   assign unused_inputs = ^{bad_value, pc_in[1:0], mtvec[1:0]};

   // Priority encode the pending trap; a machine trap from execute outranks
   // anything fetch/decode reports for the same cycle.
   always_comb begin
      trap_hit   = 1'b1;
      trap_cause = CAUSE_ILLEGAL;
      if (XB_exception_machine_trap) begin
         trap_cause = CAUSE_ILLEGAL;
      end else if (FD_exception_instruction_misaligned) begin
         trap_cause = CAUSE_INSTR_MISALIGN;
      end else if (FD_exception_illegal_instruction) begin
         trap_cause = CAUSE_ILLEGAL;
      end else if (FD_exception_unsupported_category) begin
         trap_cause = CAUSE_ILLEGAL;
      end else if (FD_exception_memory_misaligned) begin
         trap_cause = is_store ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
      end else if (ebreak) begin
         trap_cause = CAUSE_BREAKPOINT;
      end else if (ecall) begin
         trap_cause = CAUSE_ECALL_M;
      end else begin
         trap_hit   = 1'b0;
         trap_cause = 4'd0;
      end
   end

   // Saturating trap counter next value.
   always_comb begin
      trap_taken = (state == ST_IDLE) && trap_hit;
      count_next = trap_count;
      if (trap_taken && (trap_count != 16'hFFFF)) begin
         count_next = trap_count + 16'd1;
      end
   end

`ifdef TRAP_MTVAL_EN
   logic [31:0] mtval_q;
   logic [31:0] mtval_next;

   // ebreak reports its own PC, ecall reports nothing, faults report the
   // offending address or instruction word.
   always_comb begin
      mtval_next = bad_value;
      if (trap_cause == CAUSE_BREAKPOINT) begin
         mtval_next = pc_in;
      end else if (trap_cause == CAUSE_ECALL_M) begin
         mtval_next = 32'h0;
      end
   end

   assign mtval_out = mtval_q;
`else
   assign mtval_out = 32'h0;
`endif

   // Sequencer FSM with registered outputs and trap CSR capture.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         state          <= ST_IDLE;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'h0;
         trap_we        <= 1'b0;
         busy           <= 1'b0;
         mepc_out       <= 32'h0;
         mcause_out     <= 32'h0;
         trap_count     <= 16'h0;
`ifdef TRAP_MTVAL_EN
         mtval_q        <= 32'h0;
`endif
      end else begin
         trap_count <= count_next;
         trap_we    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (trap_hit) begin
                  state       <= ST_FLUSH;
                  flush       <= 1'b1;
                  busy        <= 1'b1;
                  trap_we     <= 1'b1;
                  redirect_pc <= {mtvec[31:2], 2'b00};
                  mepc_out    <= {pc_in[31:2], 2'b00};
                  mcause_out  <= {28'h0, trap_cause};
`ifdef TRAP_MTVAL_EN
                  mtval_q     <= mtval_next;
`endif
               end else if (mret) begin
                  state       <= ST_FLUSH;
                  flush       <= 1'b1;
                  busy        <= 1'b1;
                  redirect_pc <= mepc_in;
               end
            end
            ST_FLUSH: begin
               state          <= ST_REDIRECT;
               flush          <= 1'b0;
               redirect_valid <= 1'b1;
            end
            ST_REDIRECT: begin
               if (redirect_ready) begin
                  state          <= ST_IDLE;
                  redirect_valid <= 1'b0;
                  busy           <= 1'b0;
               end
            end
            default: begin
               state          <= ST_IDLE;
               flush          <= 1'b0;
               redirect_valid <= 1'b0;
               busy           <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed vector table, randomized transactions
// against a transaction-level reference, and reset / saturation sequences.
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        resetb;
   logic        fd_im, fd_ii, fd_uc, fd_mm, is_store, xb_mt;
   logic        ecall, ebreak, mret;
   logic [31:0] pc_in, bad_value, mtvec, mepc_in;
   logic        redirect_ready;
   logic        flush, redirect_valid, trap_we, busy;
   logic [31:0] redirect_pc, mepc_out, mcause_out, mtval_out;
   logic [15:0] trap_count;

   int n_err = 0;
   int n_checks = 0;

   // Reference architectural state.
   logic [31:0] m_mepc, m_mcause, m_mtval;
   int          m_count;

   trap_sequencer dut (
      .clk(clk), .resetb(resetb),
      .FD_exception_instruction_misaligned(fd_im),
      .FD_exception_illegal_instruction(fd_ii),
      .FD_exception_unsupported_category(fd_uc),
      .FD_exception_memory_misaligned(fd_mm),
      .is_store(is_store),
      .XB_exception_machine_trap(xb_mt),
      .ecall(ecall), .ebreak(ebreak), .mret(mret),
      .pc_in(pc_in), .bad_value(bad_value), .mtvec(mtvec), .mepc_in(mepc_in),
      .redirect_ready(redirect_ready),
      .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .trap_we(trap_we), .mepc_out(mepc_out), .mcause_out(mcause_out),
      .mtval_out(mtval_out), .busy(busy), .trap_count(trap_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [6:0]  ev;      // {xb, im, ii, uc, mm, ebreak, ecall}
      logic        st;
      logic        mr;
      logic [31:0] pc;
      logic [31:0] bad;
      logic [31:0] tvec;
      logic [31:0] mepc;
      int          wait_n;
      int          exp_cause; // -1 nothing happens, -2 mret redirect only
   } vec_t;

   vec_t tbl[12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic set_ev(input logic [6:0] ev, input logic st, input logic mr);
      {xb_mt, fd_im, fd_ii, fd_uc, fd_mm, ebreak, ecall} = ev;
      is_store = st;
      mret = mr;
   endtask

   // Cause from the trap priority list; -2 for a lone mret, -1 for nothing.
   function automatic int ref_cause(input logic [6:0] ev, input logic st, input logic mr);
      int prio[7];
      prio = '{2, 0, 2, 2, 4, 3, 11};
      if (st) prio[4] = 6;
      for (int p = 0; p < 7; p++) begin
         if (ev[6-p]) return prio[p];
      end
      return mr ? -2 : -1;
   endfunction

   function automatic logic [31:0] ref_mtval(input int cause, input logic [31:0] pc,
                                             input logic [31:0] bad);
`ifdef TRAP_MTVAL_EN
      if (cause == 3) return pc;
      if (cause == 11) return 32'h0;
      return bad;
`else
      return 32'h0;
`endif
   endfunction

   task automatic do_txn(input logic [6:0] ev, input logic st, input logic mr,
                         input logic [31:0] pc, input logic [31:0] bad,
                         input logic [31:0] tvec, input logic [31:0] mepc,
                         input int wait_n, input int exp_cause, input string tag);
      logic [31:0] target;
      logic        trap;
      trap = (exp_cause >= 0);
      set_ev(ev, st, mr);
      pc_in = pc; bad_value = bad; mtvec = tvec; mepc_in = mepc;
      redirect_ready = 1'b0;
      step();
      if (exp_cause == -1) begin
         set_ev(7'd0, 1'b0, 1'b0);
         check1({tag, " idle busy"}, busy, 1'b0);
         check1({tag, " idle trap_we"}, trap_we, 1'b0);
         check1({tag, " idle flush"}, flush, 1'b0);
         check({tag, " idle count"}, {16'h0, trap_count}, 32'(m_count));
         return;
      end
      if (trap) begin
         m_mepc   = {pc[31:2], 2'b00};
         m_mcause = 32'(exp_cause);
         m_mtval  = ref_mtval(exp_cause, pc, bad);
         if (m_count < 65535) m_count++;
         target = {tvec[31:2], 2'b00};
      end else begin
         target = mepc;
      end
      // cycle +1: FLUSH
      check1({tag, " c1 flush"}, flush, 1'b1);
      check1({tag, " c1 trap_we"}, trap_we, trap);
      check1({tag, " c1 busy"}, busy, 1'b1);
      check1({tag, " c1 redirect_valid"}, redirect_valid, 1'b0);
      check({tag, " c1 mepc"}, mepc_out, m_mepc);
      check({tag, " c1 mcause"}, mcause_out, m_mcause);
      check({tag, " c1 mtval"}, mtval_out, m_mtval);
      check({tag, " c1 count"}, {16'h0, trap_count}, 32'(m_count));
      set_ev(7'($urandom) | 7'b0010000, 1'($urandom), 1'($urandom));
      step();
      // cycle +2: REDIRECT
      check1({tag, " c2 redirect_valid"}, redirect_valid, 1'b1);
      check({tag, " c2 redirect_pc"}, redirect_pc, target);
      check1({tag, " c2 flush"}, flush, 1'b0);
      check1({tag, " c2 trap_we"}, trap_we, 1'b0);
      check1({tag, " c2 busy"}, busy, 1'b1);
      for (int k = 0; k < wait_n; k++) begin
         set_ev(7'($urandom) | 7'b0010000, 1'($urandom), 1'($urandom));
         step();
         check1({tag, " hold redirect_valid"}, redirect_valid, 1'b1);
         check({tag, " hold redirect_pc"}, redirect_pc, target);
         check({tag, " hold mcause"}, mcause_out, m_mcause);
         check({tag, " hold count"}, {16'h0, trap_count}, 32'(m_count));
      end
      redirect_ready = 1'b1;
      step();
      set_ev(7'd0, 1'b0, 1'b0);
      redirect_ready = 1'b0;
      check1({tag, " done busy"}, busy, 1'b0);
      check1({tag, " done redirect_valid"}, redirect_valid, 1'b0);
      check1({tag, " done flush"}, flush, 1'b0);
      check({tag, " done mcause"}, mcause_out, m_mcause);
      check({tag, " done mepc"}, mepc_out, m_mepc);
      check({tag, " done count"}, {16'h0, trap_count}, 32'(m_count));
   endtask

   task automatic check_all_zero(input string tag);
      check1({tag, " busy"}, busy, 1'b0);
      check1({tag, " flush"}, flush, 1'b0);
      check1({tag, " redirect_valid"}, redirect_valid, 1'b0);
      check1({tag, " trap_we"}, trap_we, 1'b0);
      check({tag, " redirect_pc"}, redirect_pc, 32'h0);
      check({tag, " mepc"}, mepc_out, 32'h0);
      check({tag, " mcause"}, mcause_out, 32'h0);
      check({tag, " mtval"}, mtval_out, 32'h0);
      check({tag, " count"}, {16'h0, trap_count}, 32'h0);
   endtask

   initial begin
      logic [6:0] rev;
      logic       rst, rmr;

      tbl[0]  = '{7'b0010000, 1'b0, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0000_0200, 32'h0, 0, 2};
      tbl[1]  = '{7'b1000100, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_0003, 32'h0000_0300, 32'h0, 1, 2};
      tbl[2]  = '{7'b0000100, 1'b1, 1'b0, 32'h0000_0208, 32'h0000_1006, 32'h0000_0301, 32'h0, 0, 6};
      tbl[3]  = '{7'b0000100, 1'b0, 1'b0, 32'h0000_020C, 32'h0000_1003, 32'h0000_0200, 32'h0, 2, 4};
      tbl[4]  = '{7'b0000010, 1'b0, 1'b0, 32'h0000_020E, 32'h0000_0055, 32'h0000_0203, 32'h0, 0, 3};
      tbl[5]  = '{7'b0000001, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0077, 32'h0000_0200, 32'h0000_0400, 0, 11};
      tbl[6]  = '{7'b0000000, 1'b0, 1'b1, 32'h0000_0000, 32'h0, 32'h0000_0200, 32'h0000_0400, 1, -2};
      tbl[7]  = '{7'b0000000, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0011, 32'h0000_0200, 32'h0000_0400, 0, -1};
      tbl[8]  = '{7'b0110000, 1'b0, 1'b0, 32'h0000_0402, 32'h0000_0402, 32'h0000_0200, 32'h0, 0, 0};
      tbl[9]  = '{7'b0001011, 1'b0, 1'b0, 32'h0000_0500, 32'h1234_5678, 32'h0000_0600, 32'h0, 0, 2};
      tbl[10] = '{7'b0000011, 1'b0, 1'b0, 32'h0000_0504, 32'h0000_0009, 32'h0000_0600, 32'h0, 0, 3};
      tbl[11] = '{7'b0010000, 1'b0, 1'b0, 32'h0000_0700, 32'h0000_0013, 32'h0000_0800, 32'h0, 5, 2};

      resetb = 1'b0;
      set_ev(7'h7F, 1'b1, 1'b1);
      pc_in = 32'h100; bad_value = 32'h5; mtvec = 32'h200; mepc_in = 32'h400;
      redirect_ready = 1'b0;
      step();
      step();
      check_all_zero("reset");
      set_ev(7'd0, 1'b0, 1'b0);
      resetb = 1'b1;
      m_mepc = 32'h0; m_mcause = 32'h0; m_mtval = 32'h0; m_count = 0;
      step();
      check1("post reset busy", busy, 1'b0);

      for (int i = 0; i < 12; i++) begin
         do_txn(tbl[i].ev, tbl[i].st, tbl[i].mr, tbl[i].pc, tbl[i].bad, tbl[i].tvec,
                tbl[i].mepc, tbl[i].wait_n, tbl[i].exp_cause, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 40; i++) begin
         rev = 7'($urandom) & 7'($urandom);
         rst = 1'($urandom);
         rmr = 1'($urandom);
         do_txn(rev, rst, rmr, $urandom, $urandom, $urandom, $urandom,
                $urandom_range(0, 3), ref_cause(rev, rst, rmr), $sformatf("rnd%0d", i));
      end

      // Reset while flushing abandons the trap.
      set_ev(7'b0010000, 1'b0, 1'b0);
      pc_in = 32'h0000_0900; mtvec = 32'h0000_0A00;
      step();
      check1("rst_flush pre flush", flush, 1'b1);
      resetb = 1'b0;
      step();
      check_all_zero("rst_flush");
      resetb = 1'b1;
      set_ev(7'd0, 1'b0, 1'b0);
      m_mepc = 32'h0; m_mcause = 32'h0; m_mtval = 32'h0; m_count = 0;
      step();
      check1("rst_flush after busy", busy, 1'b0);

      // Reset while redirecting, with events held during reset.
      set_ev(7'b0000001, 1'b0, 1'b0);
      step();
      set_ev(7'd0, 1'b0, 1'b0);
      step();
      check1("rst_redir pre valid", redirect_valid, 1'b1);
      resetb = 1'b0;
      set_ev(7'h7F, 1'b0, 1'b1);
      step();
      check_all_zero("rst_redir");
      step();
      check_all_zero("rst_hold");
      resetb = 1'b1;
      set_ev(7'd0, 1'b0, 1'b0);
      step();
      check1("rst_redir after busy", busy, 1'b0);
      check("rst_redir after count", {16'h0, trap_count}, 32'h0);

      // Preload the counter next to saturation, then take three traps.
      force dut.count_next = 16'hFFFE;
      step();
      release dut.count_next;
      m_count = 65534;
      check("sat preload", {16'h0, trap_count}, 32'h0000_FFFE);
      for (int i = 0; i < 3; i++) begin
         do_txn(7'b0000001, 1'b0, 1'b0, 32'h0000_0C00 + 32'(i * 4), 32'h0, 32'h0000_0D00,
                32'h0, 0, 11, $sformatf("sat%0d", i));
      end
      check("sat final", {16'h0, trap_count}, 32'h0000_FFFF);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
